// File: rtl/alu_seq_core.sv
// Sequential ALU: 16-op command set on WIDTH-bit operands with a 2*WIDTH result,
// valid/ready on both sides, multi-cycle shift-add MUL and restoring DIV.
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         command,
  input  logic               oe,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] d_out,
  output logic               err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_INC  = 4'h1, OP_SUB  = 4'h2, OP_DEC  = 4'h3,
    OP_MUL  = 4'h4, OP_DIV  = 4'h5, OP_SHL  = 4'h6, OP_SHR  = 4'h7,
    OP_INV  = 4'h8, OP_AND  = 4'h9, OP_OR   = 4'hA, OP_NAND = 4'hB,
    OP_NOR  = 4'hC, OP_XOR  = 4'hD, OP_XNOR = 4'hE, OP_BUF  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  opcode_e              op_q, op_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // MUL keeps the multiplicand here, DIV keeps the divisor
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  // MUL: {partial product, remaining multiplier}; DIV: {remainder, quotient/dividend}
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic                 err_q, err_d;

  function automatic logic [2*WIDTH-1:0] alu_comb(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] r;
    logic [WIDTH:0]     s;
    r = '0;
    s = '0;
    case (op)
      OP_ADD:  r[WIDTH:0] = {1'b0, x} + {1'b0, y};
      OP_INC:  r[WIDTH:0] = {1'b0, x} + (WIDTH+1)'(1);
      OP_SUB: begin
        s = {1'b0, x} - {1'b0, y};
        r = {{(WIDTH-1){s[WIDTH]}}, s};
      end
      OP_DEC: begin
        s = {1'b0, x} - (WIDTH+1)'(1);
        r = {{(WIDTH-1){s[WIDTH]}}, s};
      end
      OP_SHL:  r[WIDTH:0]   = {x, 1'b0};
      OP_SHR:  r[WIDTH-1:0] = x >> 1;
      OP_INV:  r[WIDTH-1:0] = ~x;
      OP_AND:  r[WIDTH-1:0] = x & y;
      OP_OR:   r[WIDTH-1:0] = x | y;
      OP_NAND: r[WIDTH-1:0] = ~(x & y);
      OP_NOR:  r[WIDTH-1:0] = ~(x | y);
      OP_XOR:  r[WIDTH-1:0] = x ^ y;
      OP_XNOR: r[WIDTH-1:0] = ~(x ^ y);
      OP_BUF:  r[WIDTH-1:0] = x;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One shift-add multiply step and one restoring-divide step per cycle
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_rsh;
  logic [WIDTH-1:0]     div_sub;
  logic                 div_borrow;
  logic [2*WIDTH-1:0]   div_next;

  always_comb begin
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]}
             + {1'b0, (work_q[0] ? opnd_q : {WIDTH{1'b0}})};
    mul_next = {mul_sum, work_q[WIDTH-1:1]};

    div_rsh    = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_borrow = (div_rsh < {1'b0, opnd_q});
    // the true difference is below the divisor, so WIDTH bits hold it exactly
    div_sub    = div_rsh[WIDTH-1:0] - opnd_q;
    if (div_borrow)
      div_next = {div_rsh[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
    else
      div_next = {div_sub, work_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    work_d    = work_q;
    res_d     = res_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d  = opcode_e'(command);
          err_d = 1'b0;
          if (command == OP_MUL) begin
            opnd_d  = a;
            work_d  = {{WIDTH{1'b0}}, b};
            cnt_d   = CW'(WIDTH);
            state_d = S_EXEC;
          end else if (command == OP_DIV) begin
            opnd_d  = b;
            work_d  = {{WIDTH{1'b0}}, a};
            cnt_d   = CW'(WIDTH);
            state_d = S_EXEC;
          end else begin
            res_d   = alu_comb(command, a, b);
            state_d = S_DONE;
          end
        end
      end
      S_EXEC: begin
        work_d = (op_q == OP_MUL) ? mul_next : div_next;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = work_d;
          err_d   = (op_q == OP_DIV) && (opnd_q == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      opnd_q  <= '0;
      work_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      work_q  <= work_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign d_out = oe ? res_q : '0;
  assign err   = err_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core at WIDTH=8 with hand-computed results.
module tb_alu_seq_core;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  command;
  logic        oe;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] d_out;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq_core #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .command(command), .oe(oe), .out_valid(out_valid),
    .out_ready(out_ready), .d_out(d_out), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE, wait for the result, check it, then retire it.
  task automatic do_op(input string tag, input logic [3:0] c, input logic [7:0] x,
                       input logic [7:0] y, input logic [15:0] exp_d,
                       input logic exp_e, input int exp_lat);
    int n;
    check({tag, ".rdy"}, {31'b0, in_ready}, 32'd1);
    command  = c;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = ~x;
    b        = ~y;
    command  = 4'h0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".lat"}, n, exp_lat);
    check({tag, ".d"}, {16'b0, d_out}, {16'b0, exp_d});
    check({tag, ".err"}, {31'b0, err}, {31'b0, exp_e});
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; command = '0;
    oe = 1'b1; out_ready = 1'b1;
    #12;
    check("rst.rdy", {31'b0, in_ready}, 32'd1);
    check("rst.ov",  {31'b0, out_valid}, 32'd0);
    check("rst.d",   {16'b0, d_out}, 32'd0);
    check("rst.err", {31'b0, err}, 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // ADD 2+1, single-cycle latency
    command = 4'h0; a = 8'd2; b = 8'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("add.ov",  {31'b0, out_valid}, 32'd1);
    check("add.rdy", {31'b0, in_ready}, 32'd0);
    check("add.d",   {16'b0, d_out}, 32'h0003);
    check("add.err", {31'b0, err}, 32'd0);
    tick();
    check("add.idle", {30'b0, in_ready, out_valid}, 32'b10);

    // MUL FF*FF: 8 busy cycles, operands scrambled while busy
    command = 4'h4; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    tick();
    a = 8'h00; b = 8'h00; command = 4'h5;
    for (int i = 0; i < 8; i++) begin
      check("mul.busy", {30'b0, in_ready, out_valid}, 32'b00);
      tick();
    end
    in_valid = 1'b0;
    check("mul.ov", {31'b0, out_valid}, 32'd1);
    check("mul.d",  {16'b0, d_out}, 32'hFE01);
    tick();

    do_op("div",    4'h5, 8'd200, 8'd7,  16'h041C, 1'b0, 8);
    do_op("div0",   4'h5, 8'd5,   8'd0,  16'h05FF, 1'b1, 8);
    do_op("addclr", 4'h0, 8'd3,   8'd4,  16'h0007, 1'b0, 0);
    do_op("sub",    4'h2, 8'd1,   8'd2,  16'hFFFF, 1'b0, 0);
    do_op("shl",    4'h6, 8'h81,  8'h00, 16'h0102, 1'b0, 0);
    do_op("sub+",   4'h2, 8'd5,   8'd3,  16'h0002, 1'b0, 0);
    do_op("dec0",   4'h3, 8'h00,  8'h55, 16'hFFFF, 1'b0, 0);
    do_op("addc",   4'h0, 8'hFF,  8'hFF, 16'h01FE, 1'b0, 0);
    do_op("shr",    4'h7, 8'h81,  8'h00, 16'h0040, 1'b0, 0);
    do_op("inv",    4'h8, 8'h0F,  8'hAA, 16'h00F0, 1'b0, 0);
    do_op("and",    4'h9, 8'hF0,  8'h3C, 16'h0030, 1'b0, 0);
    do_op("or",     4'hA, 8'hF0,  8'h3C, 16'h00FC, 1'b0, 0);
    do_op("nand",   4'hB, 8'hF0,  8'h3C, 16'h00CF, 1'b0, 0);
    do_op("nor",    4'hC, 8'hF0,  8'h3C, 16'h0003, 1'b0, 0);
    do_op("xor",    4'hD, 8'hF0,  8'h3C, 16'h00CC, 1'b0, 0);
    do_op("xnor",   4'hE, 8'hF0,  8'h3C, 16'h0033, 1'b0, 0);
    do_op("buf",    4'hF, 8'hA5,  8'h5A, 16'h00A5, 1'b0, 0);
    do_op("mul2",   4'h4, 8'd12,  8'd13, 16'h009C, 1'b0, 8);
    do_op("div2",   4'h5, 8'd255, 8'd16, 16'h0F0F, 1'b0, 8);

    // Backpressure: result held, new requests ignored, oe gates only d_out
    out_ready = 1'b0;
    command = 4'h0; a = 8'h10; b = 8'h20; in_valid = 1'b1;
    tick();
    command = 4'hF; a = 8'h55;
    for (int i = 0; i < 3; i++) begin
      check("bp.hs", {30'b0, in_ready, out_valid}, 32'b01);
      check("bp.d",  {16'b0, d_out}, 32'h0030);
      tick();
    end
    oe = 1'b0;
    #1;
    check("oe.d",  {16'b0, d_out}, 32'd0);
    check("oe.ov", {31'b0, out_valid}, 32'd1);
    oe = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp.idle", {30'b0, in_ready, out_valid}, 32'b10);
    check("bp.keep", {16'b0, d_out}, 32'h0030);

    // Reset in the middle of a MUL
    command = 4'h4; a = 8'd3; b = 8'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mrst.busy", {30'b0, in_ready, out_valid}, 32'b00);
    rst_n = 1'b0;
    #1;
    check("mrst.hs", {30'b0, in_ready, out_valid}, 32'b10);
    check("mrst.d",  {16'b0, d_out}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_op("inc", 4'h1, 8'hFF, 8'h00, 16'h0100, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
